// File: rtl/timer_pkg.sv
// Shared constants and load-sanitising helpers for the egg-timer countdown datapath.
package timer_pkg;

   localparam int DIGIT_W          = 4;
   localparam int SEC_TENS_MAX     = 5;
   localparam int DIGIT_MAX        = 9;
   localparam int TICK_DIV_DEFAULT = 50000000;
   localparam int PRE_W_DEFAULT    = 26;

   // Bit positions of each BCD digit inside time_bcd.
   localparam int SEC_ONES_LSB = 0;
   localparam int SEC_TENS_LSB = 4;
   localparam int MIN_ONES_LSB = 8;
   localparam int MIN_TENS_LSB = 12;

   typedef logic [DIGIT_W-1:0] digit_t;

   // Limit one BCD digit to max_d; an out-of-range switch setting becomes the limit.
   function automatic digit_t clamp_digit(input digit_t d, input digit_t max_d);
      return (d > max_d) ? max_d : d;
   endfunction

   // Sanitise a {tens, ones} switch pair; the tens limit differs for seconds and minutes.
   function automatic logic [7:0] sanitise_pair(input logic [7:0] raw, input digit_t tens_max);
      return {clamp_digit(raw[7:4], tens_max), clamp_digit(raw[3:0], digit_t'(DIGIT_MAX))};
   endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of the ripple-borrow decrementer: wraps 0 -> MAX and borrows onward.
module bcd_digit_dec
   import timer_pkg::*;
#(
   parameter int MAX = 9
) (
   input  logic [DIGIT_W-1:0] digit,
   input  logic               borrow_in,
   output logic [DIGIT_W-1:0] digit_next,
   output logic               borrow_out
);

   // Pass the digit through unless borrowed from; 0 wraps to MAX and propagates the borrow.
   always_comb begin
      digit_next = digit;
      borrow_out = 1'b0;
      if (borrow_in) begin
         if (digit == '0) begin
            digit_next = digit_t'(MAX);
            borrow_out = 1'b1;
         end else begin
            digit_next = digit - digit_t'(1);
         end
      end
   end

endmodule

// File: rtl/countdown_sequencer.sv
// MM:SS countdown datapath: switch loads with clamping, one-second prescaled
// decrement down to 00:00, and the LED blink pattern used while flashing.
// Handshake note: secs_load/mins_load are single-cycle strobes acted on at the
// next rising edge; dec_en and flash_en are levels sampled every edge.
module countdown_sequencer
   import timer_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEFAULT,
   parameter int PRE_W    = PRE_W_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  sw_value,
   input  logic        secs_load,
   input  logic        mins_load,
   input  logic        dec_en,
   input  logic        flash_en,
   output logic [15:0] time_bcd,
   output logic        time_flat,
   output logic        tick,
   output logic [9:0]  ledr
);

   localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(TICK_DIV - 1);
   localparam logic [PRE_W-1:0] BLINK_LAST = PRE_W'(TICK_DIV / 2 - 1);
   localparam logic [PRE_W-1:0] CNT_ONE    = PRE_W'(1);

   logic [15:0]      time_q;
   logic [PRE_W-1:0] pre_q;
   logic             tick_q;
   logic [PRE_W-1:0] blink_cnt;
   logic             blink_q;
   logic             flash_d;

   logic [DIGIT_W-1:0] sec_ones_n, sec_tens_n, min_ones_n, min_tens_n;
   logic               b_sec_ones, b_sec_tens, b_min_ones, b_min_tens;
   logic [15:0]        time_dec;
   logic               load_any;
   logic               run_en;
   logic               do_dec;
   logic [7:0]         secs_clean;
   logic [7:0]         mins_clean;

   // Ripple-borrow decrement chain, seconds ones first.
   bcd_digit_dec #(.MAX(DIGIT_MAX)) u_sec_ones (
      .digit      (time_q[SEC_ONES_LSB +: DIGIT_W]),
      .borrow_in  (1'b1),
      .digit_next (sec_ones_n),
      .borrow_out (b_sec_ones)
   );

   bcd_digit_dec #(.MAX(SEC_TENS_MAX)) u_sec_tens (
      .digit      (time_q[SEC_TENS_LSB +: DIGIT_W]),
      .borrow_in  (b_sec_ones),
      .digit_next (sec_tens_n),
      .borrow_out (b_sec_tens)
   );

   bcd_digit_dec #(.MAX(DIGIT_MAX)) u_min_ones (
      .digit      (time_q[MIN_ONES_LSB +: DIGIT_W]),
      .borrow_in  (b_sec_tens),
      .digit_next (min_ones_n),
      .borrow_out (b_min_ones)
   );

   bcd_digit_dec #(.MAX(DIGIT_MAX)) u_min_tens (
      .digit      (time_q[MIN_TENS_LSB +: DIGIT_W]),
      .borrow_in  (b_min_ones),
      .digit_next (min_tens_n),
      .borrow_out (b_min_tens)
   );

   // Decode of the decrement / load conditions for this edge; load beats decrement.
   always_comb begin
      time_dec   = {min_tens_n, min_ones_n, sec_tens_n, sec_ones_n};
      load_any   = secs_load | mins_load;
      run_en     = dec_en & ~time_flat;
      // A borrow out of the top digit would mean wrapping past 00:00; never allow it.
      do_dec     = run_en & (pre_q == PRE_LAST) & ~load_any & ~b_min_tens;
      secs_clean = sanitise_pair(sw_value, digit_t'(SEC_TENS_MAX));
      mins_clean = sanitise_pair(sw_value, digit_t'(DIGIT_MAX));
   end

   // Time register, prescaler and tick pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         time_q <= '0;
         pre_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         tick_q <= do_dec;
         if (load_any) begin
            pre_q <= '0;
            if (secs_load) time_q[7:0]  <= secs_clean;
            if (mins_load) time_q[15:8] <= mins_clean;
         end else if (run_en) begin
            if (pre_q == PRE_LAST) begin
               pre_q <= '0;
               if (do_dec) time_q <= time_dec;
            end else begin
               pre_q <= pre_q + CNT_ONE;
            end
         end
      end
   end

   // Blink generator: starts lit on the first flash cycle, toggles every half second.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flash_d   <= 1'b0;
         blink_cnt <= '0;
         blink_q   <= 1'b0;
      end else begin
         flash_d <= flash_en;
         if (!flash_en) begin
            blink_cnt <= '0;
            blink_q   <= 1'b0;
         end else if (!flash_d) begin
            blink_cnt <= '0;
            blink_q   <= 1'b1;
         end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_q   <= ~blink_q;
         end else begin
            blink_cnt <= blink_cnt + CNT_ONE;
         end
      end
   end

   // Output drive.
   always_comb begin
      time_bcd  = time_q;
      time_flat = (time_q == 16'h0000);
      tick      = tick_q;
      ledr      = {10{blink_q}};
   end

endmodule

// File: tb/tb_countdown_sequencer.sv
// Bench for countdown_sequencer: directed scenarios then random stimulus, all
// checked every cycle against a seconds-count reference model.
module tb_countdown_sequencer;

   localparam int TD = 4;
   localparam int PW = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  sw_value;
   logic        secs_load, mins_load, dec_en, flash_en;
   logic [15:0] time_bcd;
   logic        time_flat, tick;
   logic [9:0]  ledr;

   int n_total = 0;
   int n_bad   = 0;

   // reference model state
   int   m_min, m_sec, m_pre, m_fk;
   logic m_tick;

   countdown_sequencer #(.TICK_DIV(TD), .PRE_W(PW)) dut (
      .clk       (clk),
      .reset     (reset),
      .sw_value  (sw_value),
      .secs_load (secs_load),
      .mins_load (mins_load),
      .dec_en    (dec_en),
      .flash_en  (flash_en),
      .time_bcd  (time_bcd),
      .time_flat (time_flat),
      .tick      (tick),
      .ledr      (ledr)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int clamp_i(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   function automatic logic [15:0] model_bcd();
      return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
   endfunction

   function automatic logic [9:0] model_ledr();
      return (m_fk >= 0 && ((m_fk / (TD / 2)) % 2 == 0)) ? 10'h3FF : 10'h000;
   endfunction

   task automatic model_reset();
      m_min = 0; m_sec = 0; m_pre = 0; m_fk = -1; m_tick = 1'b0;
   endtask

   // One clock edge of behaviour, with time held as a plain count of seconds.
   task automatic model_edge();
      int total;
      if (!reset) begin
         model_reset();
      end else begin
         total  = m_min * 60 + m_sec;
         m_tick = 1'b0;
         if (secs_load || mins_load) begin
            m_pre = 0;
            if (secs_load)
               m_sec = clamp_i(int'(sw_value[7:4]), 5) * 10 + clamp_i(int'(sw_value[3:0]), 9);
            if (mins_load)
               m_min = clamp_i(int'(sw_value[7:4]), 9) * 10 + clamp_i(int'(sw_value[3:0]), 9);
         end else if (dec_en && total != 0) begin
            if (m_pre == TD - 1) begin
               m_pre  = 0;
               total  = total - 1;
               m_min  = total / 60;
               m_sec  = total % 60;
               m_tick = 1'b1;
            end else begin
               m_pre++;
            end
         end
         if (!flash_en) m_fk = -1;
         else           m_fk++;
      end
   endtask

   task automatic compare_all();
      check_val("time_bcd", 32'(time_bcd), 32'(model_bcd()));
      check_val("time_flat", 32'(time_flat), 32'(model_bcd() == 16'h0000));
      check_val("tick", 32'(tick), 32'(m_tick));
      check_val("ledr", 32'(ledr), 32'(model_ledr()));
   endtask

   // driver: advance one edge, update the model, then sample away from the edge
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic load_secs(input logic [7:0] v);
      sw_value = v; secs_load = 1'b1; step(); secs_load = 1'b0;
   endtask

   task automatic load_mins(input logic [7:0] v);
      sw_value = v; mins_load = 1'b1; step(); mins_load = 1'b0;
   endtask

   initial begin
      reset = 1'b0; sw_value = 8'h00;
      secs_load = 1'b0; mins_load = 1'b0; dec_en = 1'b0; flash_en = 1'b0;
      model_reset();
      #2;
      check_val("rst_time", 32'(time_bcd), 32'h0);
      check_val("rst_flat", 32'(time_flat), 32'h1);
      check_val("rst_ledr", 32'(ledr), 32'h0);
      check_val("rst_tick", 32'(tick), 32'h0);
      steps(2);
      reset = 1'b1;

      // idle at 00:00 with dec_en: nothing moves
      dec_en = 1'b1;
      steps(20);
      check_val("idle_time", 32'(time_bcd), 32'h0);
      dec_en = 1'b0;

      // 01:07 countdown across the minute boundary
      load_secs(8'h07);
      load_mins(8'h01);
      check_val("load_0107", 32'(time_bcd), 32'h0107);
      dec_en = 1'b1;
      steps(3);
      check_val("pre_notick", 32'(tick), 32'h0);
      step();
      check_val("first_dec", 32'(time_bcd), 32'h0106);
      check_val("first_tick", 32'(tick), 32'h1);
      steps(28);
      check_val("borrow_0059", 32'(time_bcd), 32'h0059);
      dec_en = 1'b0;

      // clamping
      load_secs(8'hAF);
      check_val("clamp_sec", 32'(time_bcd[7:0]), 32'h59);
      load_mins(8'hF3);
      check_val("clamp_min", 32'(time_bcd[15:8]), 32'h93);

      // pause / resume keeps the partial second
      load_secs(8'h10);
      load_mins(8'h00);
      dec_en = 1'b1; steps(2);
      dec_en = 1'b0; steps(10);
      dec_en = 1'b1; step();
      check_val("resume_wait", 32'(tick), 32'h0);
      step();
      check_val("resume_tick", 32'(tick), 32'h1);
      check_val("resume_0009", 32'(time_bcd), 32'h0009);

      // load on the terminal prescaler count wins over the decrement
      steps(3);
      load_secs(8'h30);
      check_val("load_wins", 32'(time_bcd), 32'h0030);
      check_val("load_notick", 32'(tick), 32'h0);

      // both strobes together load both fields from one value
      dec_en = 1'b0;
      sw_value = 8'h42; secs_load = 1'b1; mins_load = 1'b1; step();
      secs_load = 1'b0; mins_load = 1'b0;
      check_val("both_load", 32'(time_bcd), 32'h4242);

      // run down to zero and stay there
      load_secs(8'h02);
      load_mins(8'h00);
      dec_en = 1'b1;
      steps(8);
      check_val("flat_time", 32'(time_bcd), 32'h0);
      check_val("flat_flag", 32'(time_flat), 32'h1);
      steps(20);
      dec_en = 1'b0;

      // flash pattern, then async reset mid-blink
      load_secs(8'h25);
      flash_en = 1'b1; steps(12);
      flash_en = 1'b0; step();
      check_val("flash_off", 32'(ledr), 32'h0);
      flash_en = 1'b1; steps(1);
      check_val("flash_on", 32'(ledr), 32'h3FF);
      #3 reset = 1'b0;
      #1;
      check_val("async_ledr", 32'(ledr), 32'h0);
      check_val("async_time", 32'(time_bcd), 32'h0);
      check_val("async_flat", 32'(time_flat), 32'h1);
      model_reset();
      flash_en = 1'b0;
      step();
      reset = 1'b1;

      // random traffic, biased toward short times so countdowns finish
      for (int i = 0; i < 3000; i++) begin
         secs_load = ($urandom_range(0, 15) == 0);
         mins_load = ($urandom_range(0, 15) == 0);
         sw_value  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
         if ($urandom_range(0, 19) == 0) dec_en   = ~dec_en;
         if ($urandom_range(0, 39) == 0) flash_en = ~flash_en;
         step();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
